// File: rtl/mem_copier_pkg.sv
// mem_copier shared definitions.
// FSM encoding and cache-port word constants.
package mem_copier_pkg;

    localparam int WORD_BYTES = 4;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/mem_copier_if.sv
// mem_copier cache port.
// Word-wide request bus with busy/ready flow control.
interface mem_copier_if #(
    parameter int ADDRESS_BITWIDTH = 32
);

    logic [ADDRESS_BITWIDTH-1:0] ca_address;
    logic [31:0]                 ca_data_in;
    logic [3:0]                  ca_write_enable;
    logic [31:0]                 ca_data_out;
    logic                        ca_data_out_ready;
    logic                        ca_busy;

    modport master (
        output ca_address,
        output ca_data_in,
        output ca_write_enable,
        input  ca_data_out,
        input  ca_data_out_ready,
        input  ca_busy
    );

    modport slave (
        input  ca_address,
        input  ca_data_in,
        input  ca_write_enable,
        output ca_data_out,
        output ca_data_out_ready,
        output ca_busy
    );

endinterface

// File: rtl/mem_copier.sv
// mem_copier: word-by-word memory copy / pattern fill engine
// driving a single cache port, one outstanding access at a time.
module mem_copier
    import mem_copier_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int LEN_BITWIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        fill,
    input  logic [ADDRESS_BITWIDTH-1:0] src,
    input  logic [ADDRESS_BITWIDTH-1:0] dst,
    input  logic [LEN_BITWIDTH-1:0]     len,
    input  logic [31:0]                 pattern,
    output logic                        active,
    output logic                        done,
    mem_copier_if.master                ca
);

    localparam int AW = ADDRESS_BITWIDTH;
    localparam int LW = LEN_BITWIDTH;

    state_e          state_q, state_d;
    logic [AW-1:0]   src_q, dst_q;
    logic [LW-1:0]   cnt_q;
    logic            fill_q;
    logic [31:0]     pattern_q;
    logic [31:0]     buf_q;
    logic            rd_take;
    logic            wr_step;
    logic            accept;
    logic            unused_bits;

    assign unused_bits = ^{src[1:0], dst[1:0]};

    assign accept  = (state_q == IDLE) && start;
    assign rd_take = (state_q == RD_WAIT) && ca.ca_data_out_ready
                     && !ca.ca_busy;
    assign wr_step = (state_q == WR_WAIT) && !ca.ca_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        ca.ca_address      = '0;
        ca.ca_data_in      = '0;
        ca.ca_write_enable = '0;
        active             = 1'b0;
        done               = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_d = DONE;
                    else if (fill)
                        state_d = WR_REQ;
                    else
                        state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                active        = 1'b1;
                ca.ca_address = src_q;
                if (!ca.ca_busy)
                    state_d = RD_WAIT;
            end
            RD_WAIT: begin
                active        = 1'b1;
                ca.ca_address = src_q;
                if (rd_take)
                    state_d = WR_REQ;
            end
            WR_REQ: begin
                active             = 1'b1;
                ca.ca_address      = dst_q;
                ca.ca_data_in      = fill_q ? pattern_q : buf_q;
                ca.ca_write_enable = WE_WORD;
                if (!ca.ca_busy)
                    state_d = WR_WAIT;
            end
            WR_WAIT: begin
                active             = 1'b1;
                ca.ca_address      = dst_q;
                ca.ca_data_in      = fill_q ? pattern_q : buf_q;
                ca.ca_write_enable = WE_WORD;
                // cnt_q is the count before this word retires
                if (wr_step) begin
                    if (cnt_q == LW'(1))
                        state_d = DONE;
                    else if (fill_q)
                        state_d = WR_REQ;
                    else
                        state_d = RD_REQ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            fill_q    <= 1'b0;
            pattern_q <= '0;
            buf_q     <= '0;
        end else begin
            if (accept) begin
                src_q     <= {src[AW-1:2], 2'b00};
                dst_q     <= {dst[AW-1:2], 2'b00};
                cnt_q     <= len;
                fill_q    <= fill;
                pattern_q <= pattern;
            end
            if (rd_take)
                buf_q <= ca.ca_data_out;
            if (wr_step) begin
                src_q <= src_q + AW'(WORD_BYTES);
                dst_q <= dst_q + AW'(WORD_BYTES);
                cnt_q <= cnt_q - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_copier.sv
// Self-checking bench for mem_copier with a small
// behavioural cache (line-miss latency) and write scoreboard.
module tb_mem_copier;
    import mem_copier_pkg::*;

    localparam int AW = 32;
    localparam int LW = 16;
    localparam int MISS_LAT = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic          fill = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [LW-1:0] len = '0;
    logic [31:0]   pattern = '0;
    logic          active;
    logic          done;

    mem_copier_if #(.ADDRESS_BITWIDTH(AW)) ca ();

    mem_copier #(
        .ADDRESS_BITWIDTH(AW),
        .LEN_BITWIDTH(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .fill(fill),
        .src(src),
        .dst(dst),
        .len(len),
        .pattern(pattern),
        .active(active),
        .done(done),
        .ca(ca)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic [15:0] present;
    int          miss_cnt;

    assign ca.ca_busy           = (miss_cnt != 0);
    assign ca.ca_data_out_ready = !ca.ca_busy;
    assign ca.ca_data_out       = mem[ca.ca_address[7:2]];

    always @(posedge clk)
        if (ca.ca_write_enable != 4'h0 && !ca.ca_busy)
            mem[ca.ca_address[7:2]] <= ca.ca_data_in;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            miss_cnt <= 0;
        else if (miss_cnt != 0)
            miss_cnt <= miss_cnt - 1;
        else if (active && !present[ca.ca_address[7:4]]) begin
            present[ca.ca_address[7:4]] <= 1'b1;
            miss_cnt <= MISS_LAT;
        end
    end

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   rd_cycles = 0;
    int   we_cycles = 0;
    int   busy_active = 0;
    int   busy_idle = 0;
    logic phase = 1'b0;

    // every second accepted write edge of a word is its commit
    always @(negedge clk) begin
        wr_t e;
        if (done) done_seen++;
        if (active && ca.ca_write_enable == 4'h0) rd_cycles++;
        if (ca.ca_write_enable != 4'h0) we_cycles++;
        if (ca.ca_busy && active) busy_active++;
        if (ca.ca_busy && !active) busy_idle++;
        if (!active)
            phase = 1'b0;
        else if (ca.ca_write_enable == WE_WORD && !ca.ca_busy) begin
            if (phase) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: addr=%h data=%h, none expected",
                             ca.ca_address, ca.ca_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if (ca.ca_address !== e.addr || ca.ca_data_in !== e.data) begin
                        errors++;
                        $display("FAIL wr_commit: got addr=%h data=%h, want addr=%h data=%h",
                                 ca.ca_address, ca.ca_data_in, e.addr, e.data);
                    end
                end
            end
            phase = ~phase;
        end
    end

    task automatic issue(input logic f, input logic [AW-1:0] s,
                         input logic [AW-1:0] d, input logic [LW-1:0] l,
                         input logic [31:0] p);
        @(negedge clk);
        start = 1'b1; fill = f; src = s; dst = d; len = l; pattern = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, done, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({active, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: active/done=%b, want 00", {active, done});
        end
        checks++;
        if (ca.ca_write_enable !== 4'h0 || ca.ca_address !== '0 || ca.ca_data_in !== '0) begin
            errors++;
            $display("FAIL reset_bus: we=%h addr=%h data=%h, want 0/0/0",
                     ca.ca_write_enable, ca.ca_address, ca.ca_data_in);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.cnt_q !== '0 || dut.buf_q !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d cnt=%h buf=%h, want IDLE/0/0",
                     dut.state_q, dut.cnt_q, dut.buf_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_copy();
        int d0 = done_seen;
        int r0 = rd_cycles;
        exp_q.push_back({32'd64, 32'hAB4C3E6F});
        exp_q.push_back({32'd68, 32'h9D8E2F17});
        issue(1'b0, 32'd8, 32'd64, 16'd2, 32'h0);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL copy_first_start: active=%b, want 1", active);
        end
        wait_done("copy");
        checks++;
        if (done_seen - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL copy_done: pulses=%0d pending=%0d, want 1/0",
                     done_seen - d0, exp_q.size());
        end
        checks++;
        if (mem[16] !== 32'hAB4C3E6F || mem[17] !== 32'h9D8E2F17) begin
            errors++;
            $display("FAIL copy_mem: @64=%h @68=%h, want AB4C3E6F/9D8E2F17",
                     mem[16], mem[17]);
        end
        checks++;
        if (rd_cycles - r0 == 0) begin
            errors++;
            $display("FAIL copy_reads: read cycles=%0d, want >0", rd_cycles - r0);
        end
    endtask

    task automatic test_miss();
        int ba = busy_active;
        int bi = busy_idle;
        exp_q.push_back({32'd32, 32'hD5B8A9C4});
        issue(1'b0, 32'd16, 32'd32, 16'd1, 32'h0);
        wait_done("miss");
        checks++;
        if (mem[8] !== 32'hD5B8A9C4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL miss_mem: @32=%h pending=%0d, want D5B8A9C4/0",
                     mem[8], exp_q.size());
        end
        checks++;
        if (busy_active - ba == 0 || busy_idle - bi != 0) begin
            errors++;
            $display("FAIL miss_active: busy&active=%0d busy&!active=%0d, want >0/0",
                     busy_active - ba, busy_idle - bi);
        end
    endtask

    task automatic test_start_ignored();
        int d0 = done_seen;
        exp_q.push_back({32'd128, 32'hAB4C3E6F});
        exp_q.push_back({32'd132, 32'h9D8E2F17});
        issue(1'b0, 32'd8, 32'd128, 16'd2, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy: active=%b at second start, want 1", active);
        end
        start = 1'b1; fill = 1'b1; src = 32'd16; dst = 32'd160;
        len = 16'd4; pattern = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign");
        checks++;
        if (done_seen - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ign_done: pulses=%0d pending=%0d, want 1/0",
                     done_seen - d0, exp_q.size());
        end
        checks++;
        if (mem[32] !== 32'hAB4C3E6F || mem[33] !== 32'h9D8E2F17 || mem[40] !== 32'h0) begin
            errors++;
            $display("FAIL ign_mem: @128=%h @132=%h @160=%h, want AB4C3E6F/9D8E2F17/0",
                     mem[32], mem[33], mem[40]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        exp_q.push_back({32'd192, 32'hAB4C3E6F});
        exp_q.push_back({32'd196, 32'h9D8E2F17});
        issue(1'b0, 32'd8, 32'd192, 16'd2, 32'h0);
        while (ca.ca_write_enable != WE_WORD && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (dut.state_q !== WR_WAIT || ca.ca_busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_setup: state=%0d busy=%b, want WR_WAIT/1",
                     dut.state_q, ca.ca_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ca.ca_write_enable !== 4'h0 || active !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rmid_async: we=%h active=%b state=%0d, want 0/0/IDLE",
                     ca.ca_write_enable, active, dut.state_q);
        end
        checks++;
        if (ca.ca_address !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_bus: addr=%h done=%b, want 0/0", ca.ca_address, done);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        int d0 = done_seen;
        int r0 = rd_cycles;
        for (int i = 0; i < 4; i++)
            exp_q.push_back({32'(4 * i), 32'h31323334});
        issue(1'b1, 32'd0, 32'd0, 16'd4, 32'h31323334);
        wait_done("fill");
        checks++;
        if (done_seen - d0 != 1 || exp_q.size() != 0 || rd_cycles - r0 != 0) begin
            errors++;
            $display("FAIL fill_done: pulses=%0d pending=%0d reads=%0d, want 1/0/0",
                     done_seen - d0, exp_q.size(), rd_cycles - r0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== 32'h31323334) begin
                errors++;
                $display("FAIL fill_mem: @%0d=%h, want 31323334", 4 * i, mem[i]);
            end
        end
    endtask

    task automatic test_len_zero();
        int d0 = done_seen;
        int w0 = we_cycles;
        issue(1'b0, 32'd8, 32'd100, 16'd0, 32'h0);
        checks++;
        if (done !== 1'b1 || active !== 1'b0) begin
            errors++;
            $display("FAIL len0_pulse: done=%b active=%b, want 1/0", done, active);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL len0_end: done=%b state=%0d, want 0/IDLE", done, dut.state_q);
        end
        checks++;
        if (done_seen - d0 != 1 || we_cycles - w0 != 0) begin
            errors++;
            $display("FAIL len0_count: pulses=%0d we_cycles=%0d, want 1/0",
                     done_seen - d0, we_cycles - w0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[2] = 32'hAB4C3E6F;
        mem[3] = 32'h9D8E2F17;
        mem[4] = 32'hD5B8A9C4;
        present = 16'h0011;
        test_reset();
        test_copy();
        test_miss();
        test_start_ignored();
        test_reset_mid();
        test_fill();
        test_len_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
